ci_mem_copy_master: RTL and testbench
=====================================

CI_MEM_COPY_MASTER -- requirements
Module: ci_mem_copy_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word address width of the target memory slave.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter READ_LATENCY, default 1, fixed slave read latency in cycles (range 1..4).
REQ-004 SHALL have ports: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: start  in  1  command strobe; mode  in  1  0=copy, 1=fill; src_addr  in  ADDR_W  copy source base; dst_addr  in  ADDR_W  destination base; length  in  ADDR_W  word count; pattern  in  DATA_W  fill value.
REQ-006 SHALL have ports: busy  out  1  operation in progress; done  out  1  completion pulse; words_done  out  ADDR_W  words written so far.
REQ-007 SHALL have master ports: avm_address  out  ADDR_W; avm_chipselect  out  1; avm_write  out  1; avm_byteenable  out  DATA_W/8; avm_writedata  out  DATA_W; avm_readdata  in  DATA_W. There is no waitrequest; a read is chipselect=1 with write=0.

Function
REQ-008 SHALL implement states IDLE, READ, WAIT, WRITE, DONE.
REQ-009 IDLE: start=1 SHALL latch mode, src_addr, dst_addr, length, pattern; go to DONE if length=0, else READ (mode=0) or WRITE (mode=1).
REQ-010 start while not IDLE SHALL be ignored; latched command values SHALL NOT change mid-operation.
REQ-011 READ (one cycle): chipselect=1, write=0, address=current source; next state WAIT.
REQ-012 WAIT SHALL last exactly READ_LATENCY cycles with chipselect=0; avm_readdata SHALL be captured into a data register on the last WAIT cycle; next state WRITE.
REQ-013 WRITE (one cycle): chipselect=1, write=1, byteenable all ones, address=current destination, writedata=captured data (copy) or pattern (fill).
REQ-014 After WRITE: source and destination addresses SHALL increment by 1 modulo 2^ADDR_W (wrap, no error); words_done SHALL increment; if words_done reaches length, next state DONE, else READ (copy) or WRITE (fill).
REQ-015 Copy throughput SHALL be 2+READ_LATENCY cycles per word; fill SHALL be one word per cycle.
REQ-016 DONE SHALL last one cycle with done=1, then IDLE; done SHALL be 0 in all other states.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 Copy SHALL always run ascending; overlapping regions with dst_addr > src_addr produce undefined destination contents and are not checked.
REQ-019 Outside READ and WRITE, chipselect and write SHALL be 0; address and writedata are don't-care but SHALL be held stable.
REQ-020 words_done SHALL hold its final value in IDLE until the next accepted start clears it to 0.

Reset
REQ-021 reset_n=0 SHALL asynchronously force IDLE, busy=0, done=0, chipselect=0, write=0, byteenable=0, words_done=0, address=0, writedata=0.
REQ-022 Reset asserted mid-operation SHALL abort without completing the current write and without a done pulse.
REQ-023 All state and outputs SHALL be registered; no output SHALL depend combinationally on an input.

Structure
REQ-024 State encoding and mode constants (MODE_COPY, MODE_FILL) SHALL live in shared package ci_mem_pkg.
REQ-025 The block SHALL be a single module; no sub-module is required.

Verification
REQ-026 Bench SHALL pair the block with a behavioural single-port memory model (registered address, READ_LATENCY=1, no waitrequest).
REQ-027 Copy: mem[0x10..0x13]={A0,A1,A2,A3}, start mode=0 src=0x10 dst=0x100 len=4 -> mem[0x100..0x103]={A0..A3}; done pulses exactly once, 12 cycles after first READ cycle.
REQ-028 Fill: mode=1 dst=0x20 len=3 pattern=0xDEADBEEF -> three consecutive write cycles at 0x20,0x21,0x22; done on the following cycle; no read cycles.
REQ-029 Zero length: start len=0 -> no chipselect activity, busy high one cycle, done one cycle after start.
REQ-030 Wrap: copy src=0x3FFE dst=0x0000 len=4 -> reads 0x3FFE,0x3FFF,0x0000,0x0001 in order; words_done=4.
REQ-031 Abort and ignore: start during busy has no effect; reset_n low in mid-copy of len=8 -> chipselect=0 immediately, no done, next command executes normally.

Source files
------------

// File: rtl/ci_mem_pkg.sv
// Shared constants for the memory copy/fill master: FSM state encoding
// and command mode values.
package ci_mem_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Command modes
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ci_mem_copy_master.sv
// Memory copy / fill master for a fixed-latency slave without waitrequest.
// Copy moves one word per READ/WAIT/WRITE round trip; fill streams one write
// per cycle. Every output is a register loaded on the transition into the
// state that needs it, so nothing depends combinationally on an input.
module ci_mem_copy_master
    import ci_mem_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
)
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W-1:0]   length,
    input  logic [DATA_W-1:0]   pattern,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   words_done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata
);

    localparam int WCNT_W = 2;

    logic [2:0]        state;
    logic              mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] length_q;
    logic [DATA_W-1:0] pattern_q;
    logic [WCNT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] words_next;
    logic [ADDR_W-1:0] src_next;
    logic [ADDR_W-1:0] dst_next;

    // Post-write counter values; addresses wrap naturally at 2^ADDR_W
    always_comb begin
        words_next = words_done + ADDR_W'(1);
        src_next   = src_q + ADDR_W'(1);
        dst_next   = dst_q + ADDR_W'(1);
    end

    // Command FSM; bus outputs are set up on entry to READ/WRITE and otherwise held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            mode_q         <= MODE_COPY;
            src_q          <= '0;
            dst_q          <= '0;
            length_q       <= '0;
            pattern_q      <= '0;
            wait_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            words_done     <= '0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        length_q   <= length;
                        pattern_q  <= pattern;
                        words_done <= '0;
                        busy       <= 1'b1;
                        if (length == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (mode == MODE_FILL) begin
                            state          <= ST_WRITE;
                            avm_chipselect <= 1'b1;
                            avm_write      <= 1'b1;
                            avm_byteenable <= '1;
                            avm_address    <= dst_addr;
                            avm_writedata  <= pattern;
                        end else begin
                            state          <= ST_READ;
                            avm_chipselect <= 1'b1;
                            avm_write      <= 1'b0;
                            avm_address    <= src_addr;
                        end
                    end
                end
                ST_READ: begin
                    state          <= ST_WAIT;
                    avm_chipselect <= 1'b0;
                    avm_write      <= 1'b0;
                    wait_cnt       <= WCNT_W'(READ_LATENCY - 1);
                end
                ST_WAIT: begin
                    // The write data register doubles as the read capture register
                    if (wait_cnt == '0) begin
                        state          <= ST_WRITE;
                        avm_chipselect <= 1'b1;
                        avm_write      <= 1'b1;
                        avm_byteenable <= '1;
                        avm_address    <= dst_q;
                        avm_writedata  <= avm_readdata;
                    end else begin
                        wait_cnt <= wait_cnt - WCNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    src_q      <= src_next;
                    dst_q      <= dst_next;
                    words_done <= words_next;
                    if (words_next == length_q) begin
                        state          <= ST_DONE;
                        avm_chipselect <= 1'b0;
                        avm_write      <= 1'b0;
                        done           <= 1'b1;
                    end else if (mode_q == MODE_FILL) begin
                        state         <= ST_WRITE;
                        avm_address   <= dst_next;
                        avm_writedata <= pattern_q;
                    end else begin
                        state          <= ST_READ;
                        avm_chipselect <= 1'b1;
                        avm_write      <= 1'b0;
                        avm_address    <= src_next;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state          <= ST_IDLE;
                    done           <= 1'b0;
                    busy           <= 1'b0;
                    avm_chipselect <= 1'b0;
                    avm_write      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ci_mem_copy_master.sv
// Bench for ci_mem_copy_master: directed command sequence against a
// behavioural single-port memory with registered address and latency 1.
module tb_ci_mem_copy_master;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] length;
    logic [DATA_W-1:0] pattern;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] words_done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;

    // Memory model and preload port
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              pl_we;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    // Bus activity logs
    int rd_addr[$];
    int rd_cyc[$];
    int wr_addr[$];
    int wr_cyc[$];
    int done_cyc[$];
    int cyc;
    int be_err;

    int n_assert;
    int n_fail;

    ci_mem_copy_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .READ_LATENCY(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .mode(mode),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .length(length),
        .pattern(pattern),
        .busy(busy),
        .done(done),
        .words_done(words_done),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write(avm_write),
        .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: registered address, one cycle read latency
    always @(posedge clk) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (avm_chipselect && avm_write)
            mem[avm_address] <= avm_writedata;
        if (avm_chipselect && !avm_write)
            avm_readdata <= mem[avm_address];
    end

    // Bus monitor: logs each access with the cycle number it occurred in
    always @(posedge clk) begin
        if (avm_chipselect && !avm_write) begin
            rd_addr.push_back(int'(avm_address));
            rd_cyc.push_back(cyc);
        end
        if (avm_chipselect && avm_write) begin
            wr_addr.push_back(int'(avm_address));
            wr_cyc.push_back(cyc);
            if (avm_byteenable !== 4'hF) be_err++;
        end
        if (done) done_cyc.push_back(cyc);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic issue(input logic m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                         input logic [ADDR_W-1:0] l, input logic [DATA_W-1:0] p);
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = l; pattern = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int rb, wb, db;
        n_assert = 0; n_fail = 0; cyc = 0; be_err = 0;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; pattern = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;

        // ---- Reset state ----
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_cs", {63'd0, avm_chipselect}, 64'd0);
        check("rst_write", {63'd0, avm_write}, 64'd0);
        check("rst_be", {60'd0, avm_byteenable}, 64'd0);
        check("rst_words", {50'd0, words_done}, 64'd0);
        check("rst_addr", {50'd0, avm_address}, 64'd0);
        check("rst_wdata", {32'd0, avm_writedata}, 64'd0);
        reset_n = 1'b1;

        // ---- Copy 4 words 0x10 -> 0x100, with an ignored start mid-run ----
        for (int i = 0; i < 4; i++) preload(14'h10 + 14'(i), 32'hA0A0_0000 + 32'(i));
        rb = rd_addr.size(); wb = wr_addr.size(); db = done_cyc.size();
        issue(1'b0, 14'h10, 14'h100, 14'd4, 32'h0);
        check("copy_busy", {63'd0, busy}, 64'd1);
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 1'b1; src_addr = 14'h55; dst_addr = 14'h200; length = 14'd2;
        pattern = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        wait_idle("copy_idle");
        for (int i = 0; i < 4; i++)
            check($sformatf("copy_mem%0d", i), {32'd0, mem[14'h100 + 14'(i)]}, {32'd0, 32'hA0A0_0000 + 32'(i)});
        check("copy_nrd", 64'(rd_addr.size() - rb), 64'd4);
        check("copy_nwr", 64'(wr_addr.size() - wb), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("copy_rdaddr%0d", i), 64'(rd_addr[rb + i]), 64'(16'h10 + i));
            check($sformatf("copy_wraddr%0d", i), 64'(wr_addr[wb + i]), 64'(16'h100 + i));
        end
        check("copy_ndone", 64'(done_cyc.size() - db), 64'd1);
        check("copy_done_lat", 64'(done_cyc[db] - rd_cyc[rb]), 64'd12);
        check("copy_words", {50'd0, words_done}, 64'd4);
        repeat (3) @(negedge clk);
        check("hold_words", {50'd0, words_done}, 64'd4);
        check("idle_done", {63'd0, done}, 64'd0);

        // ---- Fill 3 words at 0x20 ----
        rb = rd_addr.size(); wb = wr_addr.size(); db = done_cyc.size();
        issue(1'b1, 14'h0, 14'h20, 14'd3, 32'hDEADBEEF);
        check("fill_words_clr", {50'd0, words_done}, 64'd0);
        wait_idle("fill_idle");
        check("fill_nrd", 64'(rd_addr.size() - rb), 64'd0);
        check("fill_nwr", 64'(wr_addr.size() - wb), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fill_wraddr%0d", i), 64'(wr_addr[wb + i]), 64'(16'h20 + i));
            check($sformatf("fill_wrcyc%0d", i), 64'(wr_cyc[wb + i] - wr_cyc[wb]), 64'(i));
            check($sformatf("fill_mem%0d", i), {32'd0, mem[14'h20 + 14'(i)]}, {32'd0, 32'hDEADBEEF});
        end
        check("fill_done_lat", 64'(done_cyc[db] - wr_cyc[wb]), 64'd3);
        check("fill_words", {50'd0, words_done}, 64'd3);

        // ---- Zero length ----
        rb = rd_addr.size(); wb = wr_addr.size();
        issue(1'b0, 14'h10, 14'h300, 14'd0, 32'h0);
        check("zero_busy", {63'd0, busy}, 64'd1);
        check("zero_done", {63'd0, done}, 64'd1);
        check("zero_cs", {63'd0, avm_chipselect}, 64'd0);
        @(negedge clk);
        check("zero_busy2", {63'd0, busy}, 64'd0);
        check("zero_done2", {63'd0, done}, 64'd0);
        check("zero_nacc", 64'((rd_addr.size() - rb) + (wr_addr.size() - wb)), 64'd0);

        // ---- Address wrap ----
        preload(14'h3FFE, 32'h1111_0000);
        preload(14'h3FFF, 32'h1111_0001);
        preload(14'h0000, 32'h1111_0002);
        preload(14'h0001, 32'h1111_0003);
        rb = rd_addr.size();
        issue(1'b0, 14'h3FFE, 14'h0000, 14'd4, 32'h0);
        wait_idle("wrap_idle");
        check("wrap_rd0", 64'(rd_addr[rb + 0]), 64'h3FFE);
        check("wrap_rd1", 64'(rd_addr[rb + 1]), 64'h3FFF);
        check("wrap_rd2", 64'(rd_addr[rb + 2]), 64'h0000);
        check("wrap_rd3", 64'(rd_addr[rb + 3]), 64'h0001);
        check("wrap_words", {50'd0, words_done}, 64'd4);
        check("wrap_mem0", {32'd0, mem[0]}, 64'h1111_0000);
        check("wrap_mem1", {32'd0, mem[1]}, 64'h1111_0001);
        check("wrap_mem2", {32'd0, mem[2]}, 64'h1111_0000);

        // ---- Abort by reset mid-copy, then recover ----
        db = done_cyc.size(); wb = wr_addr.size();
        issue(1'b0, 14'h10, 14'h300, 14'd8, 32'h0);
        repeat (3) @(negedge clk);
        check("abort_pre_cs", {63'd0, avm_chipselect}, 64'd1);
        check("abort_pre_words", {50'd0, words_done}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_cs", {63'd0, avm_chipselect}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_words", {50'd0, words_done}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("abort_ndone", 64'(done_cyc.size() - db), 64'd0);
        check("abort_nwr", 64'(wr_addr.size() - wb), 64'd1);
        issue(1'b1, 14'h0, 14'h40, 14'd2, 32'h1234_5678);
        wait_idle("recover_idle");
        check("recover_mem0", {32'd0, mem[14'h40]}, 64'h1234_5678);
        check("recover_mem1", {32'd0, mem[14'h41]}, 64'h1234_5678);
        check("recover_words", {50'd0, words_done}, 64'd2);
        check("recover_ndone", 64'(done_cyc.size() - db), 64'd1);
        check("byteenable", 64'(be_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
